// File: rtl/ila_fifo_readout.sv
// ila_fifo_readout: drains the ILA capture FIFO on the read clock and streams
// each sample out as bytes (LSB byte first) over a valid/ready interface.
// Optional build macro ILA_READOUT_HEADER_EN adds a fixed A5/5A header and a
// two-byte sample-count trailer around every readout.
module ila_fifo_readout #(
    parameter int SAMPLE_W = 15,
    parameter int RD_LAT   = 1
) (
    input  logic                rclk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                fifo_empty_i,
    input  logic [SAMPLE_W-1:0] fifo_do_i,
    output logic                fifo_pop_o,
    output logic [7:0]          byte_o,
    output logic                byte_valid_o,
    input  logic                byte_ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [15:0]         sample_cnt_o
);

    localparam int NBYTES = (SAMPLE_W + 7) / 8;
    localparam int SR_W   = NBYTES * 8;
    localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_POP,
        ST_WAIT,
        ST_SEND,
        ST_DONE
`ifdef ILA_READOUT_HEADER_EN
        , ST_HDR,
        ST_TRL
`endif
    } state_t;

    state_t          state;
    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_shift;
    logic [SR_W-1:0] do_ext;
    logic [BI_W-1:0] byte_idx;
    logic [1:0]      wait_cnt;

    // Sample zero-extended to whole bytes so the top byte carries zeros above SAMPLE_W.
    assign do_ext   = SR_W'(fifo_do_i);
    assign sr_shift = sr >> 8;

    // Readout sequencer; every output is registered so valid never follows ready combinationally.
    always_ff @(posedge rclk) begin
        if (rst) begin
            state        <= ST_IDLE;
            fifo_pop_o   <= 1'b0;
            byte_o       <= 8'h00;
            byte_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            sample_cnt_o <= '0;
            sr           <= '0;
            byte_idx     <= '0;
            wait_cnt     <= '0;
        end else begin
            fifo_pop_o <= 1'b0;
            done_o     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy_o <= 1'b0;
                    if (start_i) begin
                        busy_o       <= 1'b1;
                        sample_cnt_o <= '0;
`ifdef ILA_READOUT_HEADER_EN
                        state        <= ST_HDR;
                        byte_o       <= 8'hA5;
                        byte_valid_o <= 1'b1;
                        byte_idx     <= '0;
`else
                        state        <= ST_CHECK;
`endif
                    end
                end
                ST_CHECK: begin
                    if (fifo_empty_i) begin
`ifdef ILA_READOUT_HEADER_EN
                        state        <= ST_TRL;
                        byte_o       <= sample_cnt_o[7:0];
                        byte_valid_o <= 1'b1;
                        byte_idx     <= '0;
`else
                        state        <= ST_DONE;
                        done_o       <= 1'b1;
`endif
                    end else begin
                        state      <= ST_POP;
                        fifo_pop_o <= 1'b1;
                    end
                end
                ST_POP: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'(RD_LAT - 1)) begin
                        sr           <= do_ext;
                        byte_o       <= do_ext[7:0];
                        byte_valid_o <= 1'b1;
                        byte_idx     <= '0;
                        if (sample_cnt_o != 16'hFFFF) begin
                            sample_cnt_o <= sample_cnt_o + 16'd1;
                        end
                        state        <= ST_SEND;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_SEND: begin
                    if (byte_ready_i) begin
                        if (byte_idx == BI_W'(NBYTES - 1)) begin
                            byte_valid_o <= 1'b0;
                            byte_idx     <= '0;
                            state        <= ST_CHECK;
                        end else begin
                            sr       <= sr_shift;
                            byte_o   <= sr_shift[7:0];
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
`ifdef ILA_READOUT_HEADER_EN
                ST_HDR: begin
                    if (byte_ready_i) begin
                        if (byte_idx == '0) begin
                            byte_o   <= 8'h5A;
                            byte_idx <= byte_idx + 1'b1;
                        end else begin
                            byte_valid_o <= 1'b0;
                            byte_idx     <= '0;
                            state        <= ST_CHECK;
                        end
                    end
                end
                ST_TRL: begin
                    if (byte_ready_i) begin
                        if (byte_idx == '0) begin
                            byte_o   <= sample_cnt_o[15:8];
                            byte_idx <= byte_idx + 1'b1;
                        end else begin
                            byte_valid_o <= 1'b0;
                            byte_idx     <= '0;
                            done_o       <= 1'b1;
                            state        <= ST_DONE;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ila_fifo_readout.sv
// Bench for ila_fifo_readout: two instances (RD_LAT=1 and RD_LAT=3) share one
// FIFO image; a per-cycle behavioural model checks stream, pops, busy and done.
module tb_ila_fifo_readout;

    localparam int SW    = 15;
    localparam int NB    = (SW + 7) / 8;
    localparam int NI    = 2;
    localparam int DEPTH = 256;

    logic rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic                   rst;
    logic                   start;
    logic                   ready;
    logic [NI-1:0]          empty;
    logic [NI-1:0][SW-1:0]  fdo;
    logic [NI-1:0]          pop;
    logic [NI-1:0][7:0]     bo;
    logic [NI-1:0]          bv;
    logic [NI-1:0]          busy;
    logic [NI-1:0]          done;
    logic [NI-1:0][15:0]    cnt;

    ila_fifo_readout #(.SAMPLE_W(SW), .RD_LAT(1)) u_lat1 (
        .rclk(rclk), .rst(rst), .start_i(start), .fifo_empty_i(empty[0]),
        .fifo_do_i(fdo[0]), .fifo_pop_o(pop[0]), .byte_o(bo[0]),
        .byte_valid_o(bv[0]), .byte_ready_i(ready), .busy_o(busy[0]),
        .done_o(done[0]), .sample_cnt_o(cnt[0])
    );

    ila_fifo_readout #(.SAMPLE_W(SW), .RD_LAT(3)) u_lat3 (
        .rclk(rclk), .rst(rst), .start_i(start), .fifo_empty_i(empty[1]),
        .fifo_do_i(fdo[1]), .fifo_pop_o(pop[1]), .byte_o(bo[1]),
        .byte_valid_o(bv[1]), .byte_ready_i(ready), .busy_o(busy[1]),
        .done_o(done[1]), .sample_cnt_o(cnt[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // shared FIFO image, one read pointer per instance
    logic [SW-1:0] mem [0:DEPTH-1];
    int            wp;
    int            rp       [NI];
    bit            pend     [NI];
    int            pdly     [NI];
    logic [SW-1:0] pword    [NI];
    // popped words, bytes consumed, session bookkeeping
    logic [SW-1:0] plog     [NI][0:DEPTH-1];
    int            plog_n   [NI];
    int            byte_pos [NI];
    bit            sess     [NI];
    int            sess_pops[NI];
    int            hdr_cnt  [NI];
    int            trl_cnt  [NI];
    int            last_pop [NI];
    int            done_cnt [NI];
    bit            hold     [NI];
    logic [7:0]    held     [NI];
    bit            rst_prev;
    logic [7:0]    slog     [NI][0:63];
    int            slog_n   [NI];
    logic [7:0]    want     [$];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int sat16(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // next byte the stream must carry for instance k; kind 0=none 1=hdr 2=sample 3=trailer
    task automatic next_byte(input int k, output int kind, output logic [7:0] e);
        int w;
        kind = 0;
        e    = 8'h00;
`ifdef ILA_READOUT_HEADER_EN
        if (hdr_cnt[k] < 2) begin
            kind = 1;
            e    = (hdr_cnt[k] == 0) ? 8'hA5 : 8'h5A;
            return;
        end
`endif
        if (byte_pos[k] < plog_n[k] * NB) begin
            kind = 2;
            w    = int'(plog[k][byte_pos[k] / NB]);
            e    = 8'((w >> (8 * (byte_pos[k] % NB))) & 255);
            return;
        end
`ifdef ILA_READOUT_HEADER_EN
        if (trl_cnt[k] < 2) begin
            kind = 3;
            e    = 8'((sat16(sess_pops[k]) >> (8 * trl_cnt[k])) & 255);
        end
`endif
    endtask

    task automatic model_step();
        int         kind;
        logic [7:0] e;
        logic [SW-1:0] w;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            if (rst_prev) begin
                chk($sformatf("rst_pop%0d", k),   pop[k],  0);
                chk($sformatf("rst_valid%0d", k), bv[k],   0);
                chk($sformatf("rst_busy%0d", k),  busy[k], 0);
                chk($sformatf("rst_done%0d", k),  done[k], 0);
                chk($sformatf("rst_cnt%0d", k),   cnt[k],  0);
                chk($sformatf("rst_byte%0d", k),  bo[k],   0);
            end
            chk($sformatf("busy%0d", k), busy[k], sess[k]);
            if (pop[k]) begin
                chk($sformatf("pop_in_sess%0d", k), sess[k], 1);
                chk($sformatf("pop_during_send%0d", k), bv[k], 0);
                chk($sformatf("pop_underflow%0d", k), rp[k] != wp, 1);
                chk($sformatf("pop_spacing%0d", k), (cyc - last_pop[k]) >= NB + 3, 1);
                last_pop[k] = cyc;
            end
            if (hold[k]) begin
                chk($sformatf("hold_valid%0d", k), bv[k], 1);
                chk($sformatf("hold_byte%0d", k), bo[k], held[k]);
            end
            if (bv[k] && ready && !rst) begin
                next_byte(k, kind, e);
                chk($sformatf("stream_byte%0d", k), {kind != 0, bo[k]}, {1'b1, e});
                if (slog_n[k] < 64) begin
                    slog[k][slog_n[k]] = bo[k];
                    slog_n[k]++;
                end
                if (kind == 1) hdr_cnt[k]++;
                else if (kind == 2) byte_pos[k]++;
                else if (kind == 3) trl_cnt[k]++;
            end
            if (done[k]) begin
                chk($sformatf("done_in_sess%0d", k), sess[k], 1);
                chk($sformatf("done_bytes%0d", k), byte_pos[k], plog_n[k] * NB);
                chk($sformatf("done_cnt%0d", k), cnt[k], sat16(sess_pops[k]));
                chk($sformatf("done_fifo_empty%0d", k), rp[k], wp);
`ifdef ILA_READOUT_HEADER_EN
                chk($sformatf("done_hdr%0d", k), hdr_cnt[k], 2);
                chk($sformatf("done_trl%0d", k), trl_cnt[k], 2);
`endif
                done_cnt[k]++;
            end
            // FIFO behaviour: data shows up RD_LAT cycles after the pop, junk before that
            if (pop[k]) begin
                if (rp[k] != wp) begin
                    w                   = mem[rp[k]];
                    rp[k]++;
                    plog[k][plog_n[k]]  = w;
                    plog_n[k]++;
                    pend[k]             = 1'b1;
                    pdly[k]             = lat(k);
                    pword[k]            = w;
                    fdo[k]              = ~w;
                    sess_pops[k]++;
                end
            end else if (pend[k]) begin
                pdly[k]--;
                if (pdly[k] == 0) begin
                    fdo[k]  = pword[k];
                    pend[k] = 1'b0;
                end
            end
            if (rst) begin
                sess[k]     = 1'b0;
                byte_pos[k] = plog_n[k] * NB;
                pend[k]     = 1'b0;
                hdr_cnt[k]  = 0;
                trl_cnt[k]  = 0;
            end else if (start && !sess[k]) begin
                sess[k]      = 1'b1;
                sess_pops[k] = 0;
                hdr_cnt[k]   = 0;
                trl_cnt[k]   = 0;
                last_pop[k]  = -1000;
            end else if (done[k]) begin
                sess[k] = 1'b0;
            end
            hold[k]  = bv[k] && !ready && !rst;
            held[k]  = bo[k];
            empty[k] = (rp[k] == wp);
        end
        rst_prev = rst;
    endtask

    task automatic tick();
        @(negedge rclk);
        model_step();
        @(posedge rclk);
        #1;
    endtask

    task automatic run_until_idle(input string nm, input bit rnd);
        int n = 0;
        do begin
            if (rnd) begin
                ready = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 15) == 0);
            end
            tick();
            n++;
        end while ((sess[0] || sess[1]) && n < 3000);
        start = 1'b0;
        ready = 1'b1;
        chk($sformatf("%s_idle", nm), {busy[1], busy[0]}, 2'b00);
    endtask

    task automatic chk_stream(input string nm, input int k);
        chk($sformatf("%s_len%0d", nm, k), slog_n[k], want.size());
        for (int i = 0; i < want.size() && i < slog_n[k]; i++) begin
            chk($sformatf("%s_b%0d_%0d", nm, i, k), slog[k][i], want[i]);
        end
    endtask

    task automatic load(input logic [SW-1:0] w);
        mem[wp] = w;
        wp++;
    endtask

    task automatic pulse_start();
        slog_n[0] = 0;
        slog_n[1] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int d0;
        int p0;
        int n;
        rst = 1'b1; start = 1'b0; ready = 1'b1;
        empty = '1; fdo = '0; wp = 0; rst_prev = 1'b0;
        for (int k = 0; k < NI; k++) begin
            rp[k] = 0; pend[k] = 0; pdly[k] = 0; pword[k] = '0; plog_n[k] = 0;
            byte_pos[k] = 0; sess[k] = 0; sess_pops[k] = 0; hdr_cnt[k] = 0;
            trl_cnt[k] = 0; last_pop[k] = -1000; done_cnt[k] = 0; hold[k] = 0;
            held[k] = '0; slog_n[k] = 0;
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // empty FIFO: CHECK then DONE, nothing popped or streamed
        pulse_start();
`ifndef ILA_READOUT_HEADER_EN
        chk("empty_busy_c1", busy, 2'b11);
        chk("empty_done_c1", done, 2'b00);
        tick();
        chk("empty_done_c2", done, 2'b11);
        chk("empty_busy_c2", busy, 2'b11);
        tick();
        chk("empty_done_c3", done, 2'b00);
        chk("empty_busy_c3", busy, 2'b00);
        chk("empty_nostream", slog_n[0] + slog_n[1], 0);
`else
        run_until_idle("empty", 1'b0);
        want = '{8'hA5, 8'h5A, 8'h00, 8'h00};
        chk_stream("empty", 0);
`endif
        chk("empty_cnt0", cnt[0], 0);
        chk("empty_cnt1", cnt[1], 0);

        // three samples, ready tied high
        load(15'h1234); load(15'h7FFF); load(15'h0001);
        d0 = done_cnt[0]; p0 = plog_n[0];
        pulse_start();
        run_until_idle("three", 1'b0);
`ifdef ILA_READOUT_HEADER_EN
        want = '{8'hA5, 8'h5A, 8'h34, 8'h12, 8'hFF, 8'h7F, 8'h01, 8'h00, 8'h03, 8'h00};
`else
        want = '{8'h34, 8'h12, 8'hFF, 8'h7F, 8'h01, 8'h00};
`endif
        chk_stream("three", 0);
        chk_stream("three_lat3", 1);
        chk("three_cnt0", cnt[0], 3);
        chk("three_cnt1", cnt[1], 3);
        chk("three_pops", plog_n[0] - p0, 3);
        chk("three_dones", done_cnt[0] - d0, 1);

        // backpressure on the second byte of the first sample
        load(15'h1234); load(15'h0001);
        pulse_start();
        n = 0;
        while (!(bv[0] && bo[0] == 8'h12) && n < 200) begin
            tick();
            n++;
        end
        chk("bp_reached", {bv[0], bo[0]}, {1'b1, 8'h12});
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_valid_%0d", i), bv[0], 1);
            chk($sformatf("bp_byte_%0d", i), bo[0], 8'h12);
            chk($sformatf("bp_nopop_%0d", i), pop[0], 0);
        end
        ready = 1'b1;
        run_until_idle("bp", 1'b0);
`ifdef ILA_READOUT_HEADER_EN
        want = '{8'hA5, 8'h5A, 8'h34, 8'h12, 8'h01, 8'h00, 8'h02, 8'h00};
`else
        want = '{8'h34, 8'h12, 8'h01, 8'h00};
`endif
        chk_stream("bp", 0);
        chk_stream("bp_lat3", 1);

`ifdef ILA_READOUT_HEADER_EN
        // one sample with a start pulse while busy that must be dropped
        load(15'h00AB);
        d0 = done_cnt[0];
        pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_idle("hdr", 1'b0);
        want = '{8'hA5, 8'h5A, 8'hAB, 8'h00, 8'h01, 8'h00};
        chk_stream("hdr", 0);
        chk("hdr_dones", done_cnt[0] - d0, 1);
`endif

        // randomized contents, ready and stray start pulses
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) load(SW'($urandom_range(0, (1 << SW) - 1)));
            pulse_start();
            run_until_idle($sformatf("rand%0d", r), 1'b1);
        end

        // reset while the second sample is being sent, then resume
        load(15'h00A1); load(15'h00B2); load(15'h00C3);
        pulse_start();
        n = 0;
        while (!(bv[0] && cnt[0] == 16'd2) && n < 200) begin
            tick();
            n++;
        end
        chk("mid_reached", {bv[0], cnt[0]}, {1'b1, 16'd2});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_pop", pop, 2'b00);
        chk("mid_valid", bv, 2'b00);
        chk("mid_busy", busy, 2'b00);
        chk("mid_done", done, 2'b00);
        chk("mid_cnt0", cnt[0], 0);
        chk("mid_byte0", bo[0], 0);
        chk("mid_left", wp - rp[0], 1);
        tick();
        pulse_start();
        run_until_idle("mid", 1'b0);
`ifdef ILA_READOUT_HEADER_EN
        want = '{8'hA5, 8'h5A, 8'hC3, 8'h00, 8'h01, 8'h00};
`else
        want = '{8'hC3, 8'h00};
`endif
        chk_stream("mid", 0);
        chk("mid_cnt_after", cnt[0], 1);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ila_fifo_readout.md
Name: ila_fifo_readout

Overview:
- Downstream consumer of the width-cascaded capture FIFO in the ILA storage path, running on the FIFO read clock.
- On a readout request it drains the FIFO one sample at a time: assert pop, wait the BRAM read latency, latch the sample, emit it as bytes over a valid/ready stream to the host-link transmitter.
- Stops when the FIFO reports empty, then signals completion.

Parameters:
- SAMPLE_W, 15, width of one FIFO output word (FIFO slice width × slice count).
- RD_LAT, 1, cycles from fifo_pop_o high to fifo_do_i valid (1 to 3).
- NBYTES, (SAMPLE_W+7)/8, bytes per sample; derived localparam, not to be overridden.

Ports:
- rclk  input  1  sole clock; FIFO read-side clock.
- rst  input  1  synchronous reset, active-high.
- start_i  input  1  one-cycle readout request; ignored unless idle.
- fifo_empty_i  input  1  FIFO EMPTY flag.
- fifo_do_i  input  SAMPLE_W  FIFO data out.
- fifo_pop_o  output  1  FIFO POP; single-cycle pulse per sample.
- byte_o  output  8  stream data.
- byte_valid_o  output  1  stream valid.
- byte_ready_i  input  1  stream ready from transmitter.
- busy_o  output  1  high from accepted start until done pulse inclusive.
- done_o  output  1  one-cycle pulse when readout is complete.
- sample_cnt_o  output  16  samples read in the current or last readout; saturates at 16'hFFFF.

Behaviour:
- Reset (synchronous, rst high at a rclk edge): state IDLE; fifo_pop_o=0, byte_o=8'h00, byte_valid_o=0, busy_o=0, done_o=0, sample_cnt_o=0; shift register and byte index cleared.
- Reset mid-readout aborts immediately. No further pop is issued. A byte in flight is dropped.
- IDLE:
  - start_i=1 → CHECK; busy_o=1 next cycle.
  - sample_cnt_o is cleared on accepting start.
- CHECK:
  - fifo_empty_i=1 → DONE.
  - fifo_empty_i=0 → POP.
- POP: fifo_pop_o=1 for exactly this cycle → WAIT.
- WAIT:
  - Counts RD_LAT cycles.
  - On the last one, latch fifo_do_i into the shift register and increment sample_cnt_o (saturating) → SEND.
- SEND:
  - byte_o = shift register bits [7:0]; byte_valid_o=1.
  - Bits beyond SAMPLE_W in the top byte are zero.
  - Bytes are sent LSB byte first.
  - On byte_valid_o && byte_ready_i: shift right 8 and increment byte index.
  - After byte NBYTES-1 is accepted: byte_valid_o=0 → CHECK.
- Valid/ready rules:
  - byte_valid_o, once high, stays high and byte_o stays stable until accepted.
  - Valid never depends combinationally on ready.
  - Zero or more cycles may separate accepted bytes.
- DONE: done_o=1 and busy_o=1 for one cycle → IDLE; busy_o=0 next cycle.
- Pops are never issued while in SEND, so FIFO underflow is impossible: pop only follows a CHECK that saw empty=0.
- A start_i that arrives while busy is dropped, not queued.
- Sample counter wrap: it holds at 16'hFFFF; it does not wrap to 0.

Optional Feature:
- Macro: ILA_READOUT_HEADER_EN.
- Defined:
  - New state HDR is entered from IDLE on start.
  - Emits 8'hA5 then 8'h5A (two handshaked bytes), then CHECK.
  - After the empty-detect, a TRL state emits sample_cnt_o as two bytes, LSB first, before DONE.
  - Header and trailer are sent even when the FIFO is empty at start.
- Undefined: HDR and TRL states and their logic are absent; the stream carries raw sample bytes only.

Test Plan:
- Empty FIFO: fifo_empty_i=1, pulse start_i → no pop, no byte_valid_o; done_o pulses 2 cycles after start (CHECK→DONE); sample_cnt_o=0.
- Three samples with SAMPLE_W=15, RD_LAT=1, data 15'h1234, 15'h7FFF, 15'h0001, ready tied 1:
  - Expected byte stream: 34,12,FF,7F,01,00.
  - Exactly 3 pop pulses, each spaced ≥ NBYTES+3 cycles apart.
  - sample_cnt_o=3; done_o pulses once.
- Backpressure: byte_ready_i low for 5 cycles on the second byte → byte_o holds 8'h12 with valid high throughout; no pop during the stall; the stream completes unchanged.
- Latency: RD_LAT=3 with FIFO model returning data 3 cycles after pop → the latched word equals the model's word.
  - A deliberately wrong sample on cycles 1–2 after pop must not appear on the stream.
- Mid-operation reset: rst asserted while SEND of sample 2 → next cycle all outputs at reset values; a new start_i reads out the remaining FIFO contents correctly.
- With ILA_READOUT_HEADER_EN, 1 sample of 15'h00AB → stream A5,5A,AB,00,01,00; start_i pulsed while busy is ignored (single done_o).
